// File: rtl/fsm_vedacao.sv
// Bottle sealing station controller: conveyor, cork press and counter pulses.
// Optional cork-wait timeout fault is enabled by defining VEDACAO_TIMEOUT_EN.
module fsm_vedacao #(
    parameter int unsigned TEMPO_VEDACAO = 4,
    parameter int unsigned TEMPO_LIBERA  = 3,
    parameter int unsigned TIMEOUT_ROLHA = 200
) (
    input  logic       CLOCK,
    input  logic       RESET,
    input  logic       START,
    input  logic       SENSOR_GARRAFA,
    input  logic       ROLHAS_DISPONIVEIS,
    input  logic       LIMITE_DUZIAS,
    output logic       MOTOR_ESTEIRA,
    output logic       ATUADOR_VEDACAO,
    output logic       DECREMENTA_ROLHA,
    output logic       INCREMENTA_GARRAFA,
    output logic       ESPERA_ROLHA,
    output logic       FALHA_TIMEOUT,
    output logic [2:0] ESTADO
);

    typedef enum logic [2:0] {
        PARADO        = 3'd0,
        ESTEIRA       = 3'd1,
        AGUARDA_ROLHA = 3'd2,
        VEDANDO       = 3'd3,
        LIBERANDO     = 3'd4,
        FALHA         = 3'd5
    } estado_t;

    // Timer values at which each timed phase may end (timer counts from 0).
    localparam logic [7:0] VEDA_FIM    = 8'(TEMPO_VEDACAO - 1);
    localparam logic [7:0] LIBERA_FIM  = 8'(TEMPO_LIBERA - 1);
    localparam logic [7:0] TIMEOUT_FIM = 8'(TIMEOUT_ROLHA - 1);

`ifdef VEDACAO_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    estado_t    state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic       timeout_hit;
    logic       pode_rodar;

    assign timeout_hit = TIMEOUT_EN && (timer_q >= TIMEOUT_FIM);
    assign pode_rodar  = START && !LIMITE_DUZIAS;

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q <= PARADO;
            timer_q <= 8'd0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PARADO: begin
                if (pode_rodar)
                    state_d = ESTEIRA;
            end
            ESTEIRA: begin
                if (!pode_rodar)
                    state_d = PARADO;
                else if (SENSOR_GARRAFA && ROLHAS_DISPONIVEIS)
                    state_d = VEDANDO;
                else if (SENSOR_GARRAFA)
                    state_d = AGUARDA_ROLHA;
            end
            AGUARDA_ROLHA: begin
                // Bottle stays at the station when stopped; a restart re-detects it.
                if (ROLHAS_DISPONIVEIS)
                    state_d = VEDANDO;
                else if (!START)
                    state_d = PARADO;
                else if (timeout_hit)
                    state_d = FALHA;
            end
            VEDANDO: begin
                if (timer_q == VEDA_FIM)
                    state_d = LIBERANDO;
            end
            LIBERANDO: begin
                // Leaving only once the sensor clears keeps a bottle from being sealed twice.
                if ((timer_q >= LIBERA_FIM) && !SENSOR_GARRAFA)
                    state_d = pode_rodar ? ESTEIRA : PARADO;
            end
            FALHA: begin
                if (!START || !TIMEOUT_EN)
                    state_d = PARADO;
            end
            default: state_d = PARADO;
        endcase
    end

    always_comb begin
        if (state_d != state_q)
            timer_d = 8'd0;
        else if (timer_q == 8'hFF)
            timer_d = timer_q;
        else
            timer_d = timer_q + 8'd1;
    end

    // Outputs depend only on registered state and timer.
    always_comb begin
        MOTOR_ESTEIRA      = 1'b0;
        ATUADOR_VEDACAO    = 1'b0;
        DECREMENTA_ROLHA   = 1'b0;
        INCREMENTA_GARRAFA = 1'b0;
        ESPERA_ROLHA       = 1'b0;
        FALHA_TIMEOUT      = 1'b0;
        case (state_q)
            ESTEIRA: MOTOR_ESTEIRA = 1'b1;
            AGUARDA_ROLHA: ESPERA_ROLHA = 1'b1;
            VEDANDO: begin
                ATUADOR_VEDACAO  = 1'b1;
                DECREMENTA_ROLHA = (timer_q == 8'd0);
            end
            LIBERANDO: begin
                MOTOR_ESTEIRA      = 1'b1;
                INCREMENTA_GARRAFA = (timer_q == 8'd0);
            end
            FALHA: FALHA_TIMEOUT = TIMEOUT_EN;
            default: ;
        endcase
    end

    assign ESTADO = state_q;

endmodule

// File: tb/tb_fsm_vedacao.sv
// Self-checking bench for fsm_vedacao: directed scenarios plus random stimulus
// compared against a cycle-level behavioural model of the sealing station.
module tb_fsm_vedacao;

    localparam int TV = 4;
    localparam int TL = 3;
    localparam int TO = 20;
`ifdef VEDACAO_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       SENSOR_GARRAFA = 1'b0;
    logic       ROLHAS_DISPONIVEIS = 1'b0;
    logic       LIMITE_DUZIAS = 1'b0;
    logic       MOTOR_ESTEIRA, ATUADOR_VEDACAO, DECREMENTA_ROLHA, INCREMENTA_GARRAFA;
    logic       ESPERA_ROLHA, FALHA_TIMEOUT;
    logic [2:0] ESTADO;
    logic [8:0] obs;

    int checks = 0;
    int failures = 0;

    // Model: station phase (using the published state codes) and cycles spent in it.
    int m_state = 0;
    int m_cnt = 0;

    // Per-bottle observations filled by bottle_run.
    int r_wait, r_seal, r_dec, r_inc, r_lib, r_lib_motor;
    logic [2:0] r_first, r_final;

    fsm_vedacao #(
        .TEMPO_VEDACAO(TV),
        .TEMPO_LIBERA (TL),
        .TIMEOUT_ROLHA(TO)
    ) dut (
        .CLOCK             (CLOCK),
        .RESET             (RESET),
        .START             (START),
        .SENSOR_GARRAFA    (SENSOR_GARRAFA),
        .ROLHAS_DISPONIVEIS(ROLHAS_DISPONIVEIS),
        .LIMITE_DUZIAS     (LIMITE_DUZIAS),
        .MOTOR_ESTEIRA     (MOTOR_ESTEIRA),
        .ATUADOR_VEDACAO   (ATUADOR_VEDACAO),
        .DECREMENTA_ROLHA  (DECREMENTA_ROLHA),
        .INCREMENTA_GARRAFA(INCREMENTA_GARRAFA),
        .ESPERA_ROLHA      (ESPERA_ROLHA),
        .FALHA_TIMEOUT     (FALHA_TIMEOUT),
        .ESTADO            (ESTADO)
    );

    assign obs = {MOTOR_ESTEIRA, ATUADOR_VEDACAO, DECREMENTA_ROLHA, INCREMENTA_GARRAFA,
                  ESPERA_ROLHA, FALHA_TIMEOUT, ESTADO};

    always #5 CLOCK = ~CLOCK;

    function automatic void model_step(input bit s, input bit g, input bit r, input bit l);
        int nxt;
        nxt = m_state;
        case (m_state)
            0: if (s && !l) nxt = 1;
            1: begin
                if (!s || l) nxt = 0;
                else if (g)  nxt = r ? 3 : 2;
            end
            2: begin
                if (r)                             nxt = 3;
                else if (!s)                       nxt = 0;
                else if (TO_EN && m_cnt >= TO - 1) nxt = 5;
            end
            3: if (m_cnt == TV - 1) nxt = 4;
            4: if (m_cnt >= TL - 1 && !g) nxt = (s && !l) ? 1 : 0;
            5: if (!s) nxt = 0;
            default: nxt = 0;
        endcase
        if (nxt != m_state) m_cnt = 0;
        else if (m_cnt < 255) m_cnt = m_cnt + 1;
        m_state = nxt;
    endfunction

    function automatic logic [8:0] model_out();
        logic [2:0] code;
        code = 3'(m_state);
        return {(m_state == 1 || m_state == 4), (m_state == 3), (m_state == 3 && m_cnt == 0),
                (m_state == 4 && m_cnt == 0), (m_state == 2), (m_state == 5), code};
    endfunction

    // One clock: inputs change on the falling edge, outputs are sampled 1 after the rising edge.
    task automatic drive(input bit s, input bit g, input bit r, input bit l);
        @(negedge CLOCK);
        START = s; SENSOR_GARRAFA = g; ROLHAS_DISPONIVEIS = r; LIMITE_DUZIAS = l;
        @(posedge CLOCK);
        if (RESET) begin
            m_state = 0; m_cnt = 0;
        end else begin
            model_step(s, g, r, l);
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLOCK);
        RESET = 1'b1;
        START = 1'b0; SENSOR_GARRAFA = 1'b0; ROLHAS_DISPONIVEIS = 1'b0; LIMITE_DUZIAS = 1'b0;
        m_state = 0; m_cnt = 0;
        @(negedge CLOCK);
        RESET = 1'b0;
    endtask

    // Starting in ESTEIRA: a bottle arrives, corks appear after cork_delay waiting cycles,
    // the sensor stays high for lib_hold LIBERANDO cycles, LIMITE optionally raised once sealing starts.
    task automatic bottle_run(input int lib_hold, input int cork_delay, input bit lim_seal);
        bit s, g, r, l;
        r_wait = 0; r_seal = 0; r_dec = 0; r_inc = 0; r_lib = 0; r_lib_motor = 0;
        r_first = 3'd7;
        for (int k = 0; k < 100; k++) begin
            s = 1'b1;
            g = !(ESTADO == 3'd4 && r_lib >= lib_hold);
            r = (r_wait >= cork_delay);
            l = lim_seal && (r_seal > 0);
            drive(s, g, r, l);
            if (k == 0) r_first = ESTADO;
            if (ESPERA_ROLHA) r_wait++;
            if (ATUADOR_VEDACAO) r_seal++;
            if (DECREMENTA_ROLHA) r_dec++;
            if (INCREMENTA_GARRAFA) r_inc++;
            if (ESTADO == 3'd4) begin
                r_lib++;
                if (MOTOR_ESTEIRA) r_lib_motor++;
            end
            if (r_lib > 0 && ESTADO != 3'd4) break;
        end
        r_final = ESTADO;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (obs !== 9'd0) begin
            failures++; $display("FAIL reset_outputs got=%b exp=%b", obs, 9'd0);
        end
        @(negedge CLOCK);
        RESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            checks++;
            if (ESTADO !== 3'd0) begin
                failures++; $display("FAIL idle_without_start got=%0d exp=0", ESTADO);
            end
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ESTADO !== 3'd1 || MOTOR_ESTEIRA !== 1'b1) begin
            failures++; $display("FAIL first_start got=%0d/%b exp=1/1", ESTADO, MOTOR_ESTEIRA);
        end
        $display("test_reset done");
    endtask

    task automatic test_seal_basic();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        bottle_run(0, 0, 1'b0);
        checks++;
        if (r_first !== 3'd3) begin failures++; $display("FAIL seal_entry got=%0d exp=3", r_first); end
        checks++;
        if (r_seal != TV) begin failures++; $display("FAIL seal_cycles got=%0d exp=%0d", r_seal, TV); end
        checks++;
        if (r_dec != 1) begin failures++; $display("FAIL dec_pulses got=%0d exp=1", r_dec); end
        checks++;
        if (r_inc != 1) begin failures++; $display("FAIL inc_pulses got=%0d exp=1", r_inc); end
        checks++;
        if (r_lib != TL || r_lib_motor != TL) begin
            failures++; $display("FAIL eject_cycles got=%0d/%0d exp=%0d", r_lib, r_lib_motor, TL);
        end
        checks++;
        if (r_final !== 3'd1) begin failures++; $display("FAIL seal_exit got=%0d exp=1", r_final); end
        $display("test_seal_basic seal=%0d dec=%0d inc=%0d lib=%0d", r_seal, r_dec, r_inc, r_lib);
    endtask

    task automatic test_back_to_back();
        // Continues from ESTEIRA: a long-held bottle, then a cork-starved one.
        bottle_run(6, 0, 1'b0);
        checks++;
        if (r_lib != 6 || r_inc != 1) begin
            failures++; $display("FAIL long_eject got=%0d/%0d exp=6/1", r_lib, r_inc);
        end
        checks++;
        if (r_final !== 3'd1) begin failures++; $display("FAIL long_eject_exit got=%0d exp=1", r_final); end
        bottle_run(0, 10, 1'b0);
        checks++;
        if (r_first !== 3'd2) begin failures++; $display("FAIL cork_drop_route got=%0d exp=2", r_first); end
        checks++;
        if (r_wait != 10) begin failures++; $display("FAIL cork_wait got=%0d exp=10", r_wait); end
        checks++;
        if (r_dec != 1 || r_seal != TV) begin
            failures++; $display("FAIL cork_seal got=%0d/%0d exp=1/%0d", r_dec, r_seal, TV);
        end
        $display("test_back_to_back lib=%0d wait=%0d", r_lib, r_wait);
    endtask

    task automatic test_limite_in_seal();
        bottle_run(0, 0, 1'b1);
        checks++;
        if (r_seal != TV || r_inc != 1) begin
            failures++; $display("FAIL limit_seal got=%0d/%0d exp=%0d/1", r_seal, r_inc, TV);
        end
        checks++;
        if (r_final !== 3'd0) begin failures++; $display("FAIL limit_exit got=%0d exp=0", r_final); end
        $display("test_limite_in_seal final=%0d", r_final);
    endtask

    task automatic test_reset_mid_seal();
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        #2 RESET = 1'b1;
        m_state = 0; m_cnt = 0;
        #1;
        checks++;
        if (ESTADO !== 3'd0 || ATUADOR_VEDACAO !== 1'b0) begin
            failures++; $display("FAIL async_reset got=%0d/%b exp=0/0", ESTADO, ATUADOR_VEDACAO);
        end
        for (int k = 0; k < 3; k++) begin
            @(posedge CLOCK); #1;
            checks++;
            if (INCREMENTA_GARRAFA !== 1'b0 || DECREMENTA_ROLHA !== 1'b0) begin
                failures++;
                $display("FAIL reset_pulses got=%b%b exp=00", INCREMENTA_GARRAFA, DECREMENTA_ROLHA);
            end
        end
        @(negedge CLOCK);
        RESET = 1'b0; START = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ESTADO !== 3'd0) begin failures++; $display("FAIL post_reset_idle got=%0d exp=0", ESTADO); end
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        checks++;
        if (ESTADO !== 3'd1) begin failures++; $display("FAIL post_reset_start got=%0d exp=1", ESTADO); end
        $display("test_reset_mid_seal done");
    endtask

    task automatic test_cork_timeout();
        int n_wait;
        int bad_flag;
        n_wait = 0; bad_flag = 0;
        do_reset();
        drive(1'b1, 1'b0, 1'b1, 1'b0);
`ifdef VEDACAO_TIMEOUT_EN
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            if (ESTADO != 3'd2) break;
            n_wait++;
        end
        checks++;
        if (n_wait != TO) begin failures++; $display("FAIL timeout_cycles got=%0d exp=%0d", n_wait, TO); end
        checks++;
        if (ESTADO !== 3'd5 || FALHA_TIMEOUT !== 1'b1 || MOTOR_ESTEIRA !== 1'b0) begin
            failures++; $display("FAIL fault_state got=%0d/%b exp=5/1", ESTADO, FALHA_TIMEOUT);
        end
        drive(1'b1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ESTADO !== 3'd5) begin failures++; $display("FAIL fault_hold got=%0d exp=5", ESTADO); end
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        checks++;
        if (ESTADO !== 3'd0) begin failures++; $display("FAIL fault_clear got=%0d exp=0", ESTADO); end
`else
        for (int k = 0; k < 300; k++) begin
            drive(1'b1, 1'b1, 1'b0, 1'b0);
            if (ESPERA_ROLHA === 1'b1) n_wait++;
            if (FALHA_TIMEOUT !== 1'b0) bad_flag++;
        end
        checks++;
        if (n_wait != 300) begin failures++; $display("FAIL endless_wait got=%0d exp=300", n_wait); end
        checks++;
        if (bad_flag != 0) begin failures++; $display("FAIL fault_flag got=%0d exp=0", bad_flag); end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        checks++;
        if (ESTADO !== 3'd0) begin failures++; $display("FAIL wait_stop got=%0d exp=0", ESTADO); end
`endif
        $display("test_cork_timeout wait=%0d", n_wait);
    endtask

    task automatic test_random();
        int bad;
        bit s, g, r, l;
        bad = 0;
        do_reset();
        for (int k = 0; k < 1500; k++) begin
            if ($urandom_range(0, 299) == 0) do_reset();
            s = ($urandom_range(0, 11) != 0);
            g = ($urandom_range(0, 1) == 0);
            r = ($urandom_range(0, 3) != 0);
            l = ($urandom_range(0, 19) == 0);
            drive(s, g, r, l);
            checks++;
            if (obs !== model_out()) begin
                failures++; bad++;
                if (bad <= 10) $display("FAIL random_cycle%0d got=%b exp=%b", k, obs, model_out());
            end
        end
        $display("test_random mismatching_cycles=%0d", bad);
    endtask

    initial begin
        test_reset();
        test_seal_basic();
        test_back_to_back();
        test_limite_in_seal();
        test_reset_mid_seal();
        test_cork_timeout();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fsm_vedacao.md
FSM_VEDACAO -- requirements
Module: fsm_vedacao

Interface
REQ-001 SHALL have parameter TEMPO_VEDACAO, default 4, meaning cycles ATUADOR_VEDACAO is held (legal range 1..255).
REQ-002 SHALL have parameter TEMPO_LIBERA, default 3, meaning minimum conveyor cycles to eject a sealed bottle (legal range 1..255).
REQ-003 SHALL have parameter TIMEOUT_ROLHA, default 200, meaning cycles in AGUARDA_ROLHA before fault (legal range 1..255; used only with the REQ-022 macro).
REQ-004 SHALL have ports: CLOCK in 1 clock; RESET in 1 async active-high reset.
REQ-005 SHALL have ports: START in 1 line run level; SENSOR_GARRAFA in 1 bottle at sealing station; ROLHAS_DISPONIVEIS in 1 cork counter nonzero; LIMITE_DUZIAS in 1 dozen counter at 10.
REQ-006 SHALL have ports: MOTOR_ESTEIRA out 1 conveyor run; ATUADOR_VEDACAO out 1 press down; DECREMENTA_ROLHA out 1 one-cycle pulse to cork counter; INCREMENTA_GARRAFA out 1 one-cycle pulse to bottle counter.
REQ-007 SHALL have ports: ESPERA_ROLHA out 1 waiting for cork; FALHA_TIMEOUT out 1 cork-wait fault; ESTADO out 3 current state code.

Function
REQ-008 SHALL implement states PARADO=0, ESTEIRA=1, AGUARDA_ROLHA=2, VEDANDO=3, LIBERANDO=4, FALHA=5; codes 6-7 SHALL go to PARADO next cycle.
REQ-009 SHALL hold an 8-bit cycle timer, cleared on every state change and incremented each cycle otherwise, saturating at 255.
REQ-010 PARADO: all outputs 0; START=1 and LIMITE_DUZIAS=0 -> ESTEIRA.
REQ-011 ESTEIRA: MOTOR_ESTEIRA=1; START=0 or LIMITE_DUZIAS=1 -> PARADO (priority); else SENSOR_GARRAFA=1 and ROLHAS_DISPONIVEIS=1 -> VEDANDO; else SENSOR_GARRAFA=1 -> AGUARDA_ROLHA.
REQ-012 AGUARDA_ROLHA: motor 0, ESPERA_ROLHA=1; ROLHAS_DISPONIVEIS=1 -> VEDANDO; else START=0 -> PARADO (bottle stays; restart re-detects it).
REQ-013 VEDANDO: ATUADOR_VEDACAO=1, motor 0, for exactly TEMPO_VEDACAO cycles, then -> LIBERANDO; START, LIMITE_DUZIAS, ROLHAS_DISPONIVEIS ignored while sealing.
REQ-014 DECREMENTA_ROLHA SHALL be 1 only in the first cycle of VEDANDO (timer=0), exactly one pulse per sealed bottle.
REQ-015 LIBERANDO: MOTOR_ESTEIRA=1; INCREMENTA_GARRAFA=1 only in its first cycle (timer=0).
REQ-016 LIBERANDO SHALL last at least TEMPO_LIBERA cycles and until SENSOR_GARRAFA=0; then -> ESTEIRA if START=1 and LIMITE_DUZIAS=0, else PARADO.
REQ-017 A bottle SHALL never be sealed twice: re-entry to VEDANDO requires passing through ESTEIRA or AGUARDA_ROLHA after SENSOR_GARRAFA went 0.
REQ-018 ESTADO SHALL equal the current state code; all outputs decoded from registered state/timer, no input-to-output combinational paths.
REQ-019 ROLHAS_DISPONIVEIS dropping in same cycle as bottle arrival SHALL route to AGUARDA_ROLHA, not VEDANDO.

Reset
REQ-020 RESET=1 SHALL asynchronously force PARADO, timer 0, all outputs 0, ESTADO=0, including mid-VEDANDO (no DECREMENTA/INCREMENTA pulse emitted).
REQ-021 After RESET release, first transition SHALL occur on the first CLOCK edge with START=1.

Configuration
REQ-022 Macro VEDACAO_TIMEOUT_EN defined: in AGUARDA_ROLHA, timer reaching TIMEOUT_ROLHA-1 with ROLHAS_DISPONIVEIS=0 SHALL go to FALHA (ROLHAS_DISPONIVEIS=1 has priority in that cycle).
REQ-023 With macro: FALHA drives FALHA_TIMEOUT=1, other outputs 0; exits to PARADO only when START=0.
REQ-024 Without macro: FALHA unreachable, FALHA_TIMEOUT tied 0, AGUARDA_ROLHA waits indefinitely.

Verification
REQ-025 Defaults, START=1, corks available, bottle 1 cycle after ESTEIRA -> ATUADOR high 4 cycles, one DECREMENTA pulse at VEDANDO entry, one INCREMENTA pulse at LIBERANDO entry, motor on >=3 cycles.
REQ-026 SENSOR_GARRAFA held 6 cycles into LIBERANDO -> LIBERANDO lasts 6 cycles, single INCREMENTA pulse, then ESTEIRA.
REQ-027 ROLHAS_DISPONIVEIS=0 at arrival, raised 10 cycles later -> ESPERA_ROLHA=1 10 cycles, then VEDANDO, one DECREMENTA pulse.
REQ-028 Macro on, TIMEOUT_ROLHA=20, corks never arrive -> FALHA after 20 cycles in AGUARDA_ROLHA, FALHA_TIMEOUT=1; START=0 -> PARADO.
REQ-029 LIMITE_DUZIAS raised during VEDANDO -> seal completes, INCREMENTA pulses, LIBERANDO exits to PARADO.
REQ-030 RESET pulse in VEDANDO cycle 2 -> immediate PARADO, ATUADOR 0, no INCREMENTA pulse.
